// File: rtl/pq_pkg.sv
// Shared types for the priority-queue front end: key/value record,
// queue sizing and the operation code used for tracing.
package pq_pkg;

    localparam int KEY_W       = 8;
    localparam int VAL_W       = 8;
    localparam int PQ_CAPACITY = 8;

    typedef struct packed {
        logic [KEY_W-1:0] key;
        logic [VAL_W-1:0] val;
    } kv_t;

    // Key presented by an empty device; never a legal stored key.
    localparam logic [KEY_W-1:0] KEYINF = '1;

    // Bit 0 = push, bit 1 = pop.
    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_PUSH = 2'b01,
        OP_POP  = 2'b10,
        OP_BOTH = 2'b11
    } pq_op_t;

endpackage

// File: rtl/rr_arb.sv
// Combinational round-robin arbiter: first set request at or after ptr,
// wrapping around. Returns one-hot grant, its index and a found flag.
module rr_arb #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] ptr,
    output logic [NREQ-1:0]         gnt,
    output logic [$clog2(NREQ)-1:0] idx,
    output logic                    found
);

    localparam int IW = $clog2(NREQ);

    logic [IW:0]   sum;
    logic [IW-1:0] pos;

    // Rotate the search start to ptr and take the first hit.
    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        sum   = '0;
        pos   = '0;
        for (int off = 0; off < NREQ; off++) begin
            sum = {1'b0, ptr} + (IW+1)'(off);
            if (sum >= (IW+1)'(NREQ)) sum = sum - (IW+1)'(NREQ);
            pos = sum[IW-1:0];
            if (!found && req[pos]) begin
                found    = 1'b1;
                gnt[pos] = 1'b1;
                idx      = pos;
            end
        end
    end

endmodule

// File: rtl/pq_arb.sv
// Front end for one priority-queue device: round-robin push arbitration
// across NREQ producers, a one-entry registered pop buffer for a single
// consumer, and an occupancy count that gates pushes at capacity.
module pq_arb
    import pq_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter bit SIMUL = 1'b1,
    parameter int CAP   = PQ_CAPACITY
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NREQ-1:0]             req_valid,
    input  kv_t  [NREQ-1:0]             req_kv,
    output logic [NREQ-1:0]             req_rdy,
    output logic                        out_valid,
    output kv_t                         out_kv,
    input  logic                        out_rdy,
    output kv_t                         pq_idata,
    output logic                        pq_ivalid,
    input  logic                        pq_irdy,
    input  kv_t                         pq_odata,
    input  logic                        pq_ovalid,
    output logic                        pq_ordy,
    input  logic                        pq_busy,
    output logic [$clog2(CAP+1)-1:0]    count,
    output logic [$clog2(NREQ)-1:0]     grant_ptr
);

    localparam int CW = $clog2(CAP+1);
    localparam int IW = $clog2(NREQ);

    logic [CW-1:0] count_q, count_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic          out_valid_q, out_valid_d;
    kv_t           out_kv_q, out_kv_d;
    logic          rr_toggle_q, rr_toggle_d;

    logic [NREQ-1:0] gnt;
    logic [IW-1:0]   gidx;
    logic            any_req;
    logic            push_ok, pop_ok, contested, push_sel, pop_sel;
    logic            do_push, do_pop;
    pq_op_t          op;

    rr_arb #(.NREQ(NREQ)) u_rr (
        .req   (req_valid),
        .ptr   (ptr_q),
        .gnt   (gnt),
        .idx   (gidx),
        .found (any_req)
    );

    // Decide which device operations fire this cycle. A push at capacity is
    // refused even if a pop frees a slot in the same cycle.
    always_comb begin
        push_ok   = rst && !pq_busy && pq_irdy && (count_q < CW'(CAP));
        pop_ok    = rst && !pq_busy && pq_ovalid && (!out_valid_q || out_rdy);
        contested = 1'b0;
        push_sel  = 1'b1;
        pop_sel   = 1'b1;
        if (!SIMUL) begin
            contested = push_ok && any_req && pop_ok;
            push_sel  = !contested || !rr_toggle_q;
            pop_sel   = !contested ||  rr_toggle_q;
        end
        do_push = push_ok && any_req && push_sel;
        do_pop  = pop_ok && pop_sel;
    end

    assign pq_ivalid = do_push;
    assign req_rdy   = do_push ? gnt : '0;
    assign pq_idata  = req_kv[gidx];
    assign pq_ordy   = do_pop;
    assign op        = pq_op_t'({do_pop, do_push});

    assign out_valid = out_valid_q;
    assign out_kv    = out_kv_q;
    assign count     = count_q;
    assign grant_ptr = ptr_q;

    // Next state for counter, pointer, output buffer and contention toggle.
    always_comb begin
        count_d     = count_q;
        ptr_d       = ptr_q;
        out_valid_d = out_valid_q;
        out_kv_d    = out_kv_q;
        rr_toggle_d = rr_toggle_q ^ contested;
        if (do_push && !do_pop)      count_d = count_q + CW'(1);
        else if (do_pop && !do_push) count_d = count_q - CW'(1);
        if (do_push) ptr_d = (gidx == IW'(NREQ-1)) ? '0 : gidx + IW'(1);
        if (do_pop) begin
            out_valid_d = 1'b1;
            out_kv_d    = pq_odata;
        end else if (out_valid_q && out_rdy) begin
            out_valid_d = 1'b0;
        end
    end

    // State registers, cleared asynchronously together with the device.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q     <= '0;
            ptr_q       <= '0;
            out_valid_q <= 1'b0;
            out_kv_q    <= '0;
            rr_toggle_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            ptr_q       <= ptr_d;
            out_valid_q <= out_valid_d;
            out_kv_q    <= out_kv_d;
            rr_toggle_q <= rr_toggle_d;
        end
    end

    // Popping an empty queue means count and device have diverged.
    a_no_pop_empty: assert property (@(posedge clk) disable iff (!rst)
        !(((op == OP_POP) || (op == OP_BOTH)) && (count_q == '0)));

endmodule

// File: tb/tb_pq_arb.sv
// Bench for pq_arb: u0 runs with simultaneous push/pop, u1 with one
// operation per cycle. Each has a behavioural min-first queue device.
module tb_pq_arb;
    import pq_pkg::*;

    localparam int NREQ = 4;
    localparam int CAP  = PQ_CAPACITY;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic busy = 1'b0;
    always #5 clk = ~clk;

    logic [NREQ-1:0] rv [2];
    logic [NREQ-1:0] rr [2];
    kv_t  [NREQ-1:0] rkv [2];
    logic ov [2], ordy [2], hold [2], pir [2];
    logic piv [2], pord [2], pov [2];
    kv_t  okv [2], pid [2], pod [2];
    logic [3:0] cnt [2];
    logic [1:0] gp [2];

    kv_t exp0 [$];
    kv_t exp1 [$];
    int  n_chk = 0;
    int  n_fail = 0;

    pq_arb #(.NREQ(NREQ), .SIMUL(1'b1), .CAP(CAP)) u0 (
        .clk(clk), .rst(rst), .req_valid(rv[0]), .req_kv(rkv[0]), .req_rdy(rr[0]),
        .out_valid(ov[0]), .out_kv(okv[0]), .out_rdy(ordy[0]),
        .pq_idata(pid[0]), .pq_ivalid(piv[0]), .pq_irdy(pir[0]),
        .pq_odata(pod[0]), .pq_ovalid(pov[0]), .pq_ordy(pord[0]), .pq_busy(busy),
        .count(cnt[0]), .grant_ptr(gp[0]));

    pq_arb #(.NREQ(NREQ), .SIMUL(1'b0), .CAP(CAP)) u1 (
        .clk(clk), .rst(rst), .req_valid(rv[1]), .req_kv(rkv[1]), .req_rdy(rr[1]),
        .out_valid(ov[1]), .out_kv(okv[1]), .out_rdy(ordy[1]),
        .pq_idata(pid[1]), .pq_ivalid(piv[1]), .pq_irdy(pir[1]),
        .pq_odata(pod[1]), .pq_ovalid(pov[1]), .pq_ordy(pord[1]), .pq_busy(busy),
        .count(cnt[1]), .grant_ptr(gp[1]));

    // Device models: sorted storage, smallest key at the head.
    for (genvar g = 0; g < 2; g++) begin : g_dev
        kv_t  dq [$];
        logic pov_raw;
        kv_t  pod_r;
        assign pov[g] = pov_raw && !hold[g];
        assign pod[g] = pod_r;
        always @(posedge clk or negedge rst) begin
            int p;
            if (!rst) begin
                dq.delete();
                pov_raw <= 1'b0;
                pod_r   <= '{key: KEYINF, val: '0};
            end else begin
                if (!busy) begin
                    if (pord[g] && pov[g]) void'(dq.pop_front());
                    if (piv[g] && pir[g]) begin
                        p = 0;
                        while (p < dq.size() && dq[p].key <= pid[g].key) p++;
                        dq.insert(p, pid[g]);
                    end
                end
                pov_raw <= (dq.size() != 0);
                pod_r   <= (dq.size() != 0) ? dq[0] : '{key: KEYINF, val: '0};
            end
        end
    end

    function automatic kv_t mk(input logic [7:0] k);
        mk = '{key: k, val: k ^ 8'h5A};
    endfunction

    // Negedge sample point; the scoreboard pops on every output handshake.
    task sample();
        kv_t e;
        @(negedge clk);
        if (rst && ov[0] && ordy[0]) begin
            n_chk++;
            if (exp0.size() == 0) begin
                n_fail++; $display("FAIL sb0_extra got=%h exp=none", okv[0]);
            end else begin
                e = exp0.pop_front();
                if (okv[0] !== e) begin n_fail++; $display("FAIL sb0_kv got=%h exp=%h", okv[0], e); end
            end
        end
        if (rst && ov[1] && ordy[1]) begin
            n_chk++;
            if (exp1.size() == 0) begin
                n_fail++; $display("FAIL sb1_extra got=%h exp=none", okv[1]);
            end else begin
                e = exp1.pop_front();
                if (okv[1] !== e) begin n_fail++; $display("FAIL sb1_kv got=%h exp=%h", okv[1], e); end
            end
        end
    endtask

    task adv();
        @(posedge clk); #1;
    endtask

    task drain(input int i);
        bit done;
        done = 1'b0;
        for (int k = 0; k < 40 && !done; k++) begin
            sample();
            if (cnt[i] == 0 && !ov[i] && ((i == 0) ? exp0.size() : exp1.size()) == 0) done = 1'b1;
            else adv();
        end
        n_chk++;
        if (!done) begin n_fail++; $display("FAIL drain%0d got=cnt%0d ov%0b exp=empty", i, cnt[i], ov[i]); end
        adv();
    endtask

    task test_reset();
        rv[0] = 4'b1111; ordy[0] = 1'b1;
        sample();
        n_chk += 7;
        if (ov[0]   !== 1'b0) begin n_fail++; $display("FAIL rst_ov got=%b exp=0", ov[0]); end
        if (cnt[0]  !== 4'd0) begin n_fail++; $display("FAIL rst_cnt got=%0d exp=0", cnt[0]); end
        if (gp[0]   !== 2'd0) begin n_fail++; $display("FAIL rst_ptr got=%0d exp=0", gp[0]); end
        if (rr[0]   !== 4'b0) begin n_fail++; $display("FAIL rst_rdy got=%b exp=0000", rr[0]); end
        if (piv[0]  !== 1'b0) begin n_fail++; $display("FAIL rst_ivalid got=%b exp=0", piv[0]); end
        if (pord[0] !== 1'b0) begin n_fail++; $display("FAIL rst_ordy got=%b exp=0", pord[0]); end
        if (cnt[1]  !== 4'd0) begin n_fail++; $display("FAIL rst_cnt1 got=%0d exp=0", cnt[1]); end
        rv[0] = '0; ordy[0] = 1'b0;
        adv();
        rst = 1'b1;
        adv();
    endtask

    task test_rr_order();
        hold[0] = 1'b1; ordy[0] = 1'b0;
        rkv[0][0] = mk(40); rkv[0][1] = mk(30); rkv[0][2] = mk(20); rkv[0][3] = mk(10);
        rv[0] = 4'b1111;
        exp0.push_back(mk(10)); exp0.push_back(mk(20)); exp0.push_back(mk(30)); exp0.push_back(mk(40));
        for (int c = 0; c < 4; c++) begin
            sample();
            n_chk++;
            if (rr[0] !== 4'(1 << c)) begin n_fail++; $display("FAIL rr_grant%0d got=%b exp=%b", c, rr[0], 4'(1 << c)); end
            adv();
        end
        rv[0] = '0;
        sample();
        n_chk++;
        if (cnt[0] !== 4'd4) begin n_fail++; $display("FAIL rr_count got=%0d exp=4", cnt[0]); end
        adv();
        hold[0] = 1'b0; ordy[0] = 1'b1;
        drain(0);
    endtask

    task test_ptr_wrap();
        hold[0] = 1'b1; ordy[0] = 1'b0;
        rv[0] = 4'b0010; rkv[0][1] = mk(50);
        sample();
        n_chk++;
        if (rr[0] !== 4'b0010) begin n_fail++; $display("FAIL wrap_pre got=%b exp=0010", rr[0]); end
        adv();
        rv[0] = 4'b1001; rkv[0][3] = mk(33); rkv[0][0] = mk(34);
        sample();
        n_chk += 2;
        if (gp[0] !== 2'd2)    begin n_fail++; $display("FAIL wrap_ptr2 got=%0d exp=2", gp[0]); end
        if (rr[0] !== 4'b1000) begin n_fail++; $display("FAIL wrap_g3 got=%b exp=1000", rr[0]); end
        adv();
        sample();
        n_chk += 2;
        if (gp[0] !== 2'd0)    begin n_fail++; $display("FAIL wrap_ptr0 got=%0d exp=0", gp[0]); end
        if (rr[0] !== 4'b0001) begin n_fail++; $display("FAIL wrap_g0 got=%b exp=0001", rr[0]); end
        adv();
        rv[0] = '0;
        sample();
        n_chk++;
        if (gp[0] !== 2'd1) begin n_fail++; $display("FAIL wrap_ptr1 got=%0d exp=1", gp[0]); end
        exp0.push_back(mk(33)); exp0.push_back(mk(34)); exp0.push_back(mk(50));
        adv();
        hold[0] = 1'b0; ordy[0] = 1'b1;
        drain(0);
    endtask

    task test_full();
        hold[0] = 1'b1; ordy[0] = 1'b0; rv[0] = 4'b0001;
        for (int c = 0; c < CAP; c++) begin
            rkv[0][0] = mk(8'(c + 1));
            exp0.push_back(mk(8'(c + 1)));
            sample();
            n_chk++;
            if (rr[0] !== 4'b0001) begin n_fail++; $display("FAIL full_fill%0d got=%b exp=0001", c, rr[0]); end
            adv();
        end
        rkv[0][0] = mk(9);
        for (int c = 0; c < 2; c++) begin
            sample();
            n_chk += 2;
            if (cnt[0] !== 4'(CAP)) begin n_fail++; $display("FAIL full_cnt got=%0d exp=%0d", cnt[0], CAP); end
            if (rr[0] !== 4'b0 || piv[0] !== 1'b0) begin n_fail++; $display("FAIL full_block got=%b/%b exp=0000/0", rr[0], piv[0]); end
            adv();
        end
        hold[0] = 1'b0;
        sample();
        n_chk++;
        if (pord[0] !== 1'b1 || rr[0] !== 4'b0) begin n_fail++; $display("FAIL full_pop got=%b/%b exp=1/0000", pord[0], rr[0]); end
        adv();
        exp0.push_back(mk(9));
        sample();
        n_chk++;
        if (rr[0] !== 4'b0001 || cnt[0] !== 4'(CAP - 1)) begin n_fail++; $display("FAIL full_resume got=%b/%0d exp=0001/%0d", rr[0], cnt[0], CAP - 1); end
        adv();
        rv[0] = '0;
        sample();
        n_chk++;
        if (cnt[0] !== 4'(CAP)) begin n_fail++; $display("FAIL full_back got=%0d exp=%0d", cnt[0], CAP); end
        adv();
        ordy[0] = 1'b1;
        drain(0);
    endtask

    task test_busy();
        logic [3:0] c0;
        logic [1:0] g0;
        kv_t        k0;
        hold[0] = 1'b1; ordy[0] = 1'b0;
        rv[0] = 4'b0100; rkv[0][2] = mk(60);
        sample(); adv();
        rkv[0][2] = mk(61);
        sample(); adv();
        rv[0] = '0;
        exp0.push_back(mk(60)); exp0.push_back(mk(61)); exp0.push_back(mk(62));
        busy = 1'b1; hold[0] = 1'b0; ordy[0] = 1'b1; rv[0] = 4'b1111;
        rkv[0][0] = mk(62); rkv[0][1] = mk(63); rkv[0][3] = mk(64);
        c0 = 4'd2; g0 = 2'd3; k0 = okv[0];
        for (int c = 0; c < 3; c++) begin
            sample();
            n_chk += 3;
            if (rr[0] !== 4'b0 || pord[0] !== 1'b0) begin n_fail++; $display("FAIL busy_block got=%b/%b exp=0000/0", rr[0], pord[0]); end
            if (cnt[0] !== c0 || gp[0] !== g0) begin n_fail++; $display("FAIL busy_hold got=%0d/%0d exp=%0d/%0d", cnt[0], gp[0], c0, g0); end
            if (okv[0] !== k0) begin n_fail++; $display("FAIL busy_kv got=%h exp=%h", okv[0], k0); end
            adv();
        end
        busy = 1'b0; rv[0] = 4'b0001;
        sample();
        n_chk++;
        if (rr[0] !== 4'b0001 || pord[0] !== 1'b1) begin n_fail++; $display("FAIL busy_resume got=%b/%b exp=0001/1", rr[0], pord[0]); end
        adv();
        rv[0] = '0;
        drain(0);
    endtask

    task test_simul0();
        hold[1] = 1'b1; ordy[1] = 1'b1;
        rv[1] = 4'b0001; rkv[1][0] = mk(5);
        sample();
        n_chk++;
        if (rr[1] !== 4'b0001) begin n_fail++; $display("FAIL s0_seed got=%b exp=0001", rr[1]); end
        adv();
        rv[1] = 4'b0010; rkv[1][1] = mk(7); hold[1] = 1'b0;
        exp1.push_back(mk(5)); exp1.push_back(mk(7)); exp1.push_back(mk(7)); exp1.push_back(mk(7));
        for (int c = 0; c < 6; c++) begin
            sample();
            n_chk += 2;
            if ((c % 2) == 0) begin
                if (rr[1] !== 4'b0010 || pord[1] !== 1'b0) begin n_fail++; $display("FAIL s0_push%0d got=%b/%b exp=0010/0", c, rr[1], pord[1]); end
            end else begin
                if (rr[1] !== 4'b0000 || pord[1] !== 1'b1) begin n_fail++; $display("FAIL s0_pop%0d got=%b/%b exp=0000/1", c, rr[1], pord[1]); end
            end
            if (cnt[1] < 4'd1 || cnt[1] > 4'd2) begin n_fail++; $display("FAIL s0_cnt%0d got=%0d exp=1..2", c, cnt[1]); end
            adv();
        end
        rv[1] = '0;
        drain(1);
    endtask

    task test_async_reset();
        hold[0] = 1'b1; ordy[0] = 1'b0; rv[0] = 4'b0100;
        for (int c = 0; c < 4; c++) begin
            rkv[0][2] = mk(8'(70 + c));
            sample(); adv();
        end
        rv[0] = '0; hold[0] = 1'b0;
        sample(); adv();
        sample();
        n_chk++;
        if (cnt[0] !== 4'd3 || ov[0] !== 1'b1 || gp[0] !== 2'd3) begin n_fail++; $display("FAIL ar_pre got=%0d/%b/%0d exp=3/1/3", cnt[0], ov[0], gp[0]); end
        #2 rst = 1'b0;
        #1;
        n_chk += 3;
        if (ov[0]  !== 1'b0) begin n_fail++; $display("FAIL ar_ov got=%b exp=0", ov[0]); end
        if (cnt[0] !== 4'd0) begin n_fail++; $display("FAIL ar_cnt got=%0d exp=0", cnt[0]); end
        if (gp[0]  !== 2'd0) begin n_fail++; $display("FAIL ar_ptr got=%0d exp=0", gp[0]); end
        adv();
        rst = 1'b1;
        adv();
        sample();
        n_chk++;
        if (ov[0] !== 1'b0 || cnt[0] !== 4'd0 || pord[0] !== 1'b0) begin n_fail++; $display("FAIL ar_post got=%b/%0d/%b exp=0/0/0", ov[0], cnt[0], pord[0]); end
        adv();
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            rv[i] = '0; rkv[i] = '0; ordy[i] = 1'b0; hold[i] = 1'b0; pir[i] = 1'b1;
        end
        test_reset();
        test_rr_order();
        test_ptr_wrap();
        test_full();
        test_busy();
        test_simul0();
        test_async_reset();
        n_chk++;
        if (exp0.size() != 0 || exp1.size() != 0) begin n_fail++; $display("FAIL sb_left got=%0d/%0d exp=0/0", exp0.size(), exp1.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pq_arb.md
Name: pq_arb

Overview:
- Arbitration and sequencing controller in front of one priority-queue device (pq_if.dev style: idata/ivalid/irdy, odata/ovalid/ordy, full, busy).
- Shares the queue's push side between NREQ producers with round-robin grant.
- Drives the pop side into a one-entry registered output buffer for a single consumer.
- Keeps an occupancy count and schedules push/pop so that a non-single-cycle device (busy asserted) is never overdriven.

Parameters:
- NREQ, 4, number of push requesters (2..16).
- SIMUL, 1, 1 = device accepts push and pop in the same cycle; 0 = at most one operation per cycle.
- CAP, PQ_CAPACITY, queue capacity used for the occupancy counter.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- req_valid  in  NREQ  producer i has a kv to push
- req_kv  in  NREQ x kv_t  producer key/value
- req_rdy  out  NREQ  one-hot grant; push of producer i accepted this cycle
- out_valid  out  1  output buffer holds a popped kv
- out_kv  out  kv_t  popped kv (registered)
- out_rdy  in  1  consumer accepts out_kv
- pq_idata  out  kv_t  to device idata
- pq_ivalid  out  1  to device ivalid
- pq_irdy  in  1  device irdy
- pq_odata  in  kv_t  device odata
- pq_ovalid  in  1  device ovalid
- pq_ordy  out  1  to device ordy
- pq_busy  in  1  device busy
- count  out  $clog2(CAP+1)  entries in the device
- grant_ptr  out  $clog2(NREQ)  current round-robin priority pointer

Behaviour:
- Reset (rst=0, async): out_valid=0, out_kv=0, count=0, grant_ptr=0, rr_toggle=0. All outputs combinationally derived from registers or inputs go inactive: req_rdy=0, pq_ivalid=0, pq_ordy=0.
- Push eligibility: push_ok = !pq_busy && pq_irdy && (count < CAP).
- Grant: the first i with req_valid[i], searching from grant_ptr upward with wrap. Combinational, same cycle.
  - pq_ivalid = push_ok && |req_valid && push_sel.
  - req_rdy[g] = pq_ivalid. pq_idata = req_kv[g].
- grant_ptr update on a push: grant_ptr <= (g+1) mod NREQ. No push leaves grant_ptr unchanged.
- Pop eligibility: pop_ok = !pq_busy && pq_ovalid && (!out_valid || out_rdy), i.e. the buffer is empty or draining this cycle. pq_ordy = pop_ok && pop_sel.
- Pop datapath: on a pop, out_kv <= pq_odata and out_valid <= 1. If out_valid && out_rdy with no pop, out_valid <= 0.
- SIMUL=1: push_sel = pop_sel = 1, so both may occur in one cycle.
- SIMUL=0: when both are eligible, rr_toggle picks (0=push, 1=pop), and rr_toggle flips after each contested cycle. An uncontested operation proceeds and does not flip rr_toggle.
- count: +1 on push only, -1 on pop only, unchanged on both or neither. Never exceeds CAP or goes below 0. Assertion: a pop with count==0 is an error.
- Latency: producer to device is 0 cycles (combinational grant). Device head to out_kv is 1 cycle. Back-to-back pops run at 1/cycle while out_rdy stays high.
- pq_busy=1 blocks both push and pop that cycle. Registers hold.
- Full (count==CAP or !pq_irdy): all req_rdy=0. Pops continue, and a push with a pop in the same cycle at full is NOT allowed (conservative: count<CAP is required).
- Empty (!pq_ovalid): pq_ordy=0. The buffer drains normally.
- Reset asserted mid-operation clears the buffer and count immediately. The device is reset by the same rst, so the two stay consistent.
- Single producer valid: that producer is granted every eligible cycle, regardless of grant_ptr.

Decomposition:
- pq_pkg holds kv_t, KEYINF, and PQ_CAPACITY (existing). Add typedef pq_op_t {OP_NONE, OP_PUSH, OP_POP, OP_BOTH} for debug/trace.
- Sub-module rr_arb (NREQ, req vector, ptr in, one-hot grant + index out): pure combinational priority rotate, reusable.
- Output buffer, counter, and scheduling stay in pq_arb.

Test Plan:
- Reset, then req_valid=4'b1111 with keys 40,30,20,10 from req 0..3 held for 4 cycles -> grants 0,1,2,3 in order, count=4. Then out_rdy=1 -> out_kv keys 10,20,30,40 on consecutive cycles, count back to 0.
- grant_ptr=2, req_valid=4'b1001 -> req 3 granted, ptr becomes 0. Next cycle req 0 granted, ptr becomes 1.
- Fill to CAP with out_rdy=0 -> req_rdy all 0 while count==CAP. One pop with out_rdy=1 -> next cycle push resumes, count returns to CAP.
- SIMUL=0, queue holding key 5, req 1 pushing key 7, out buffer empty -> push and pop alternate across contested cycles (rr_toggle flips), count never outside 0..CAP.
- pq_busy=1 for 3 cycles with requests and pq_ovalid=1 -> no req_rdy, pq_ordy=0, and count, out_kv, and grant_ptr unchanged. Normal operation resumes in the first cycle busy=0.
- Assert rst=0 asynchronously mid-transfer with out_valid=1 and count=3 -> out_valid=0, count=0, grant_ptr=0 immediately, before the next clk edge.
